// File: rtl/bus_rr_xbar.sv
`default_nettype none
// ============================================================================
//  Module      : bus_rr_xbar
//  Description : N-host x M-device shared bus with round-robin arbitration,
//                device grant back-pressure, byte enables, pipelined
//                responses tracked by an ordered FIFO and decode-miss
//                error responses.
//  Ports       : clk_i / rst_ni         clock, async active-low reset
//                host_*                 per-host request / response channel
//                device_*               per-device request / response channel
//                cfg_device_addr_*      address map (hit when addr&mask==base)
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_rr_xbar #(
    parameter int NrHosts        = 2,
    parameter int NrDevices      = 2,
    parameter int DataWidth      = 32,
    parameter int AddressWidth   = 32,
    parameter int MaxOutstanding = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    // host side
    input  logic [NrHosts-1:0]        host_req_i,
    output logic [NrHosts-1:0]        host_gnt_o,
    input  logic [AddressWidth-1:0]   host_addr_i  [NrHosts],
    input  logic [NrHosts-1:0]        host_we_i,
    input  logic [DataWidth/8-1:0]    host_be_i    [NrHosts],
    input  logic [DataWidth-1:0]      host_wdata_i [NrHosts],
    output logic [NrHosts-1:0]        host_rvalid_o,
    output logic [DataWidth-1:0]      host_rdata_o [NrHosts],
    output logic [NrHosts-1:0]        host_err_o,
    // device side
    output logic [NrDevices-1:0]      device_req_o,
    input  logic [NrDevices-1:0]      device_gnt_i,
    output logic [AddressWidth-1:0]   device_addr_o  [NrDevices],
    output logic [NrDevices-1:0]      device_we_o,
    output logic [DataWidth/8-1:0]    device_be_o    [NrDevices],
    output logic [DataWidth-1:0]      device_wdata_o [NrDevices],
    input  logic [NrDevices-1:0]      device_rvalid_i,
    input  logic [DataWidth-1:0]      device_rdata_i [NrDevices],
    // address map
    input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
    input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices]
);

    localparam int c_HOST_IDX_W = (NrHosts > 1)   ? $clog2(NrHosts)   : 1;
    localparam int c_DEV_IDX_W  = (NrDevices > 1) ? $clog2(NrDevices) : 1;
    localparam int c_PTR_W      = $clog2(MaxOutstanding);
    localparam int c_CNT_W      = c_PTR_W + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_HOST_IDX_W-1:0] r_rr_ptr;
    logic [c_DEV_IDX_W-1:0]  r_last_dev;
    logic                    r_last_err;   // most recent issue was a decode miss
    logic [c_PTR_W-1:0]      r_wr_ptr;
    logic [c_PTR_W-1:0]      r_rd_ptr;
    logic [c_CNT_W-1:0]      r_count;

    logic [c_HOST_IDX_W-1:0] r_fifo_host [MaxOutstanding];
    logic [c_DEV_IDX_W-1:0]  r_fifo_dev  [MaxOutstanding];
    logic [MaxOutstanding-1:0] r_fifo_err;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic                    w_win_valid;
    logic [c_HOST_IDX_W-1:0] w_win_idx;
    logic [AddressWidth-1:0] w_win_addr;
    logic                    w_hit;
    logic [c_DEV_IDX_W-1:0]  w_dev;
    logic                    w_empty;
    logic                    w_full;
    logic                    w_same_target;
    logic                    w_issue_ok;
    logic                    w_grant;
    logic [c_HOST_IDX_W-1:0] w_head_host;
    logic [c_DEV_IDX_W-1:0]  w_head_dev;
    logic                    w_head_err;
    logic                    w_pop;

    // Cyclic search starting at the round-robin pointer.
    always_comb begin
        int idx;
        idx         = 0;
        w_win_valid = 1'b0;
        w_win_idx   = '0;
        for (int i = 0; i < NrHosts; i++) begin
            idx = int'(r_rr_ptr) + i;
            if (idx >= NrHosts) begin
                idx = idx - NrHosts;
            end
            if (!w_win_valid && host_req_i[idx]) begin
                w_win_valid = 1'b1;
                w_win_idx   = c_HOST_IDX_W'(idx);
            end
        end
    end

    assign w_win_addr = host_addr_i[w_win_idx];

    // Address decode; iterate downwards so the lowest matching index wins.
    always_comb begin
        w_hit = 1'b0;
        w_dev = '0;
        for (int j = NrDevices - 1; j >= 0; j--) begin
            if ((w_win_addr & cfg_device_addr_mask[j]) == cfg_device_addr_base[j]) begin
                w_hit = 1'b1;
                w_dev = c_DEV_IDX_W'(j);
            end
        end
    end

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == c_CNT_W'(MaxOutstanding));
    assign w_head_host = r_fifo_host[r_rd_ptr];
    assign w_head_dev  = r_fifo_dev[r_rd_ptr];
    assign w_head_err  = r_fifo_err[r_rd_ptr];

    // Error heads retire unconditionally; hit heads wait for their device.
    // Responses from any other device are simply not observed.
    assign w_pop = rst_ni && !w_empty && (w_head_err || device_rvalid_i[w_head_dev]);

    // A new request may only join a non-empty FIFO when it goes to the same
    // place as the most recent issue (same device, or both decode misses),
    // which guarantees responses return in FIFO order.
    assign w_same_target = w_hit ? (!r_last_err && (w_dev == r_last_dev)) : r_last_err;

    // A pop in the same cycle frees a slot, so a full FIFO does not block.
    assign w_issue_ok = rst_ni && w_win_valid && (!w_full || w_pop)
                        && (w_empty || w_same_target);
    assign w_grant    = w_issue_ok && (w_hit ? device_gnt_i[w_dev] : 1'b1);

    // ------------------------------------------------------------------
    // Output steering
    // ------------------------------------------------------------------
    always_comb begin
        host_gnt_o    = '0;
        host_rvalid_o = '0;
        host_err_o    = '0;
        device_req_o  = '0;
        device_we_o   = '0;
        for (int h = 0; h < NrHosts; h++) begin
            host_rdata_o[h] = '0;
        end
        for (int d = 0; d < NrDevices; d++) begin
            device_addr_o[d]  = '0;
            device_be_o[d]    = '0;
            device_wdata_o[d] = '0;
        end

        if (w_issue_ok && w_hit) begin
            device_req_o[w_dev]   = 1'b1;
            device_addr_o[w_dev]  = w_win_addr;
            device_we_o[w_dev]    = host_we_i[w_win_idx];
            device_be_o[w_dev]    = host_be_i[w_win_idx];
            device_wdata_o[w_dev] = host_wdata_i[w_win_idx];
        end

        if (w_grant) begin
            host_gnt_o[w_win_idx] = 1'b1;
        end

        if (w_pop) begin
            host_rvalid_o[w_head_host] = 1'b1;
            host_err_o[w_head_host]    = w_head_err;
            if (!w_head_err) begin
                host_rdata_o[w_head_host] = device_rdata_i[w_head_dev];
            end
        end
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr   <= '0;
            r_last_dev <= '0;
            r_last_err <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_grant) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_last_err <= !w_hit;
                if (w_hit) begin
                    r_last_dev <= w_dev;
                end
                r_rr_ptr <= (w_win_idx == c_HOST_IDX_W'(NrHosts - 1)) ? '0
                                                                       : w_win_idx + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_grant, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO payload needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk_i) begin
        if (w_grant) begin
            r_fifo_host[r_wr_ptr] <= w_win_idx;
            r_fifo_dev[r_wr_ptr]  <= w_hit ? w_dev : '0;
            r_fifo_err[r_wr_ptr]  <= !w_hit;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_rr_xbar.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_rr_xbar
//  Description : Self-checking bench for bus_rr_xbar: directed scenarios plus
//                a randomized run against a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_rr_xbar;

    localparam int NH = 2;
    localparam int ND = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MO = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [NH-1:0] host_req_i, host_gnt_o, host_we_i, host_rvalid_o, host_err_o;
    logic [AW-1:0] host_addr_i  [NH];
    logic [3:0]    host_be_i    [NH];
    logic [DW-1:0] host_wdata_i [NH];
    logic [DW-1:0] host_rdata_o [NH];
    logic [ND-1:0] device_req_o, device_gnt_i, device_we_o, device_rvalid_i;
    logic [AW-1:0] device_addr_o  [ND];
    logic [3:0]    device_be_o    [ND];
    logic [DW-1:0] device_wdata_o [ND];
    logic [DW-1:0] device_rdata_i [ND];
    logic [AW-1:0] cfg_base [ND];
    logic [AW-1:0] cfg_mask [ND];

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    bus_rr_xbar #(
        .NrHosts(NH), .NrDevices(ND), .DataWidth(DW),
        .AddressWidth(AW), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .host_req_i(host_req_i), .host_gnt_o(host_gnt_o),
        .host_addr_i(host_addr_i), .host_we_i(host_we_i),
        .host_be_i(host_be_i), .host_wdata_i(host_wdata_i),
        .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
        .host_err_o(host_err_o),
        .device_req_o(device_req_o), .device_gnt_i(device_gnt_i),
        .device_addr_o(device_addr_o), .device_we_o(device_we_o),
        .device_be_o(device_be_o), .device_wdata_o(device_wdata_o),
        .device_rvalid_i(device_rvalid_i), .device_rdata_i(device_rdata_i),
        .cfg_device_addr_base(cfg_base), .cfg_device_addr_mask(cfg_mask)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // a further unit later, well clear of the next edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        host_req_i      = '0;
        host_we_i       = '0;
        device_gnt_i    = '0;
        device_rvalid_i = '0;
        for (int i = 0; i < 2; i++) begin
            host_addr_i[i]    = '0;
            host_be_i[i]      = '0;
            host_wdata_i[i]   = '0;
            device_rdata_i[i] = '0;
        end
    endtask

    // Reference decode: first device whose masked compare matches, -1 on miss.
    function automatic int ref_decode(logic [AW-1:0] a);
        for (int d = 0; d < ND; d++) begin
            if ((a & cfg_mask[d]) == cfg_base[d]) return d;
        end
        return -1;
    endfunction

    task automatic test_reset();
        idle();
        rst_ni = 1'b0;
        host_req_i = 2'b11;
        host_addr_i[0] = 32'h10;
        host_addr_i[1] = 32'h20;
        device_gnt_i = 2'b11;
        device_rvalid_i = 2'b11;
        device_rdata_i[0] = 32'h1234;
        #1;
        checks++;
        if ({host_gnt_o, host_rvalid_o, host_err_o, device_req_o} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0", {host_gnt_o, host_rvalid_o, host_err_o, device_req_o});
        end
        checks++;
        if (device_addr_o[0] !== 32'h0 || host_rdata_o[0] !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: addr %h rdata %h expected 0", device_addr_o[0], host_rdata_o[0]);
        end
        tick();
        rst_ni = 1'b1;
        host_req_i = 2'b01;
        device_rvalid_i = 2'b00;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (host_gnt_o !== 2'b01 || device_req_o !== 2'b01 || device_addr_o[0] !== 32'h10) begin
                errors++;
                $display("FAIL reset_fill%0d: gnt %b req %b addr %h expected 01 01 10", c, host_gnt_o, device_req_o, device_addr_o[0]);
            end
            tick();
        end
        // Two entries outstanding; reset mid-cycle.
        rst_ni = 1'b0;
        device_rvalid_i = 2'b01;
        #1;
        checks++;
        if ({host_gnt_o, host_rvalid_o, device_req_o} !== 6'h00) begin
            errors++;
            $display("FAIL reset_mid: got %b expected 0", {host_gnt_o, host_rvalid_o, device_req_o});
        end
        tick();
        rst_ni = 1'b1;
        host_req_i = 2'b00;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (host_rvalid_o !== 2'b00) begin
                errors++;
                $display("FAIL reset_no_rvalid%0d: got %b expected 00", c, host_rvalid_o);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_gnt, exp_rv;
        idle();
        host_req_i = 2'b11;
        host_addr_i[0] = 32'h100;
        host_addr_i[1] = 32'h200;
        host_we_i = 2'b10;
        host_be_i[0] = 4'h3;
        host_be_i[1] = 4'hC;
        device_gnt_i = 2'b01;
        device_rvalid_i = 2'b01;
        for (int c = 0; c < 6; c++) begin
            if (c >= 4) host_req_i = 2'b00;
            device_rdata_i[0] = 32'hA000_0000 + c;
            #1;
            exp_gnt = (c < 4) ? (2'b01 << (c % 2)) : 2'b00;
            exp_rv  = (c >= 1 && c <= 4) ? (2'b01 << ((c - 1) % 2)) : 2'b00;
            checks++;
            if (host_gnt_o !== exp_gnt) begin
                errors++;
                $display("FAIL rr_gnt%0d: got %b expected %b", c, host_gnt_o, exp_gnt);
            end
            checks++;
            if (host_rvalid_o !== exp_rv) begin
                errors++;
                $display("FAIL rr_rvalid%0d: got %b expected %b", c, host_rvalid_o, exp_rv);
            end
            if (exp_rv != 2'b00) begin
                checks++;
                if (host_rdata_o[(c - 1) % 2] !== 32'hA000_0000 + c) begin
                    errors++;
                    $display("FAIL rr_rdata%0d: got %h expected %h", c, host_rdata_o[(c - 1) % 2], 32'hA000_0000 + c);
                end
            end
            if (c < 4) begin
                checks++;
                if (device_addr_o[0] !== ((c % 2) ? 32'h200 : 32'h100) ||
                    device_be_o[0] !== ((c % 2) ? 4'hC : 4'h3) ||
                    device_we_o !== {1'b0, (c % 2) == 1}) begin
                    errors++;
                    $display("FAIL rr_fields%0d: addr %h be %h we %b", c, device_addr_o[0], device_be_o[0], device_we_o);
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_back_pressure();
        idle();
        host_req_i = 2'b01;
        host_addr_i[0] = 32'h40;
        host_we_i = 2'b01;
        host_be_i[0] = 4'hF;
        host_wdata_i[0] = 32'hDEAD_BEEF;
        for (int c = 0; c < 4; c++) begin
            device_gnt_i = (c == 3) ? 2'b01 : 2'b00;
            #1;
            checks++;
            if (host_gnt_o !== ((c == 3) ? 2'b01 : 2'b00)) begin
                errors++;
                $display("FAIL bp_gnt%0d: got %b expected %b", c, host_gnt_o, (c == 3) ? 2'b01 : 2'b00);
            end
            checks++;
            if (device_req_o !== 2'b01 || device_addr_o[0] !== 32'h40 || device_wdata_o[0] !== 32'hDEAD_BEEF ||
                device_we_o !== 2'b01 || device_be_o[0] !== 4'hF) begin
                errors++;
                $display("FAIL bp_fields%0d: req %b addr %h wdata %h we %b be %h", c, device_req_o, device_addr_o[0], device_wdata_o[0], device_we_o, device_be_o[0]);
            end
            tick();
        end
        idle();
        device_rvalid_i = 2'b01;
        device_rdata_i[0] = 32'h77;
        #1;
        checks++;
        if (host_rvalid_o !== 2'b01 || host_rdata_o[0] !== 32'h77 || host_err_o !== 2'b00) begin
            errors++;
            $display("FAIL bp_resp: rvalid %b rdata %h err %b expected 01 77 00", host_rvalid_o, host_rdata_o[0], host_err_o);
        end
        tick();
        #1;
        checks++;
        if (host_rvalid_o !== 2'b00) begin
            errors++;
            $display("FAIL bp_drain: rvalid %b expected 00", host_rvalid_o);
        end
        tick();
        idle();
    endtask

    task automatic test_decode_miss();
        idle();
        host_req_i = 2'b10;
        host_addr_i[1] = 32'hF000_0000;
        device_gnt_i = 2'b11;
        #1;
        checks++;
        if (host_gnt_o !== 2'b10 || device_req_o !== 2'b00) begin
            errors++;
            $display("FAIL miss_gnt: gnt %b req %b expected 10 00", host_gnt_o, device_req_o);
        end
        tick();
        host_req_i = 2'b00;
        device_rvalid_i = 2'b11;
        device_rdata_i[0] = 32'hFFFF_FFFF;
        device_rdata_i[1] = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (host_rvalid_o !== 2'b10 || host_err_o !== 2'b10 || host_rdata_o[1] !== 32'h0) begin
            errors++;
            $display("FAIL miss_resp: rvalid %b err %b rdata %h expected 10 10 0", host_rvalid_o, host_err_o, host_rdata_o[1]);
        end
        tick();
        #1;
        checks++;
        if (host_rvalid_o !== 2'b00) begin
            errors++;
            $display("FAIL miss_drain: rvalid %b expected 00", host_rvalid_o);
        end
        tick();
        idle();
    endtask

    task automatic test_ordering();
        idle();
        host_req_i = 2'b01;
        host_addr_i[0] = 32'h10;
        device_gnt_i = 2'b11;
        #1;
        checks++;
        if (host_gnt_o !== 2'b01) begin
            errors++;
            $display("FAIL ord_first: gnt %b expected 01", host_gnt_o);
        end
        tick();
        host_req_i = 2'b10;
        host_addr_i[1] = 32'h1000_0020;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (host_gnt_o !== 2'b00 || device_req_o !== 2'b00) begin
                errors++;
                $display("FAIL ord_hold%0d: gnt %b req %b expected 00 00", c, host_gnt_o, device_req_o);
            end
            tick();
        end
        device_rvalid_i = 2'b01;
        device_rdata_i[0] = 32'h55;
        #1;
        checks++;
        if (host_rvalid_o !== 2'b01 || host_rdata_o[0] !== 32'h55 || host_gnt_o !== 2'b00) begin
            errors++;
            $display("FAIL ord_pop: rvalid %b rdata %h gnt %b expected 01 55 00", host_rvalid_o, host_rdata_o[0], host_gnt_o);
        end
        tick();
        device_rvalid_i = 2'b00;
        #1;
        checks++;
        if (host_gnt_o !== 2'b10 || device_req_o !== 2'b10 || device_addr_o[1] !== 32'h1000_0020) begin
            errors++;
            $display("FAIL ord_second: gnt %b req %b addr %h expected 10 10 10000020", host_gnt_o, device_req_o, device_addr_o[1]);
        end
        tick();
        host_req_i = 2'b00;
        device_rvalid_i = 2'b11;
        device_rdata_i[0] = 32'h99;
        device_rdata_i[1] = 32'h66;
        #1;
        checks++;
        if (host_rvalid_o !== 2'b10 || host_rdata_o[1] !== 32'h66 || host_rdata_o[0] !== 32'h0) begin
            errors++;
            $display("FAIL ord_resp: rvalid %b rdata1 %h rdata0 %h expected 10 66 0", host_rvalid_o, host_rdata_o[1], host_rdata_o[0]);
        end
        tick();
        #1;
        checks++;
        if (host_rvalid_o !== 2'b00) begin
            errors++;
            $display("FAIL ord_drain: rvalid %b expected 00", host_rvalid_o);
        end
        tick();
        idle();
    endtask

    task automatic test_full_fifo();
        idle();
        host_req_i = 2'b01;
        host_addr_i[0] = 32'h80;
        device_gnt_i = 2'b01;
        for (int c = 0; c < MO; c++) begin
            #1;
            checks++;
            if (host_gnt_o !== 2'b01) begin
                errors++;
                $display("FAIL full_fill%0d: gnt %b expected 01", c, host_gnt_o);
            end
            tick();
        end
        #1;
        checks++;
        if (host_gnt_o !== 2'b00 || device_req_o !== 2'b00) begin
            errors++;
            $display("FAIL full_block: gnt %b req %b expected 00 00", host_gnt_o, device_req_o);
        end
        tick();
        device_rvalid_i = 2'b01;
        device_rdata_i[0] = 32'h11;
        #1;
        checks++;
        if (host_rvalid_o !== 2'b01 || host_gnt_o !== 2'b01) begin
            errors++;
            $display("FAIL full_pop_push: rvalid %b gnt %b expected 01 01", host_rvalid_o, host_gnt_o);
        end
        tick();
        host_req_i = 2'b00;
        for (int c = 0; c < MO; c++) begin
            #1;
            checks++;
            if (host_rvalid_o !== 2'b01) begin
                errors++;
                $display("FAIL full_drain%0d: rvalid %b expected 01", c, host_rvalid_o);
            end
            tick();
        end
        #1;
        checks++;
        if (host_rvalid_o !== 2'b00) begin
            errors++;
            $display("FAIL full_empty: rvalid %b expected 00", host_rvalid_o);
        end
        tick();
        idle();
    endtask

    // Transaction-level model: an ordered list of outstanding responses, the
    // host favoured next, and per-host pending requests.
    typedef struct {
        int host;
        int dev;   // -1 for decode miss
    } txn_t;

    task automatic test_random();
        txn_t          q[$];
        txn_t          t;
        int            favour;
        bit            pend [NH];
        int            win, tgt;
        bit            pop, allowed, grant;
        logic [1:0]    exp_gnt, exp_dreq, exp_rv, exp_err;
        logic [DW-1:0] exp_rdata [NH];
        logic [AW-1:0] exp_addr;
        int            sel;

        idle();
        rst_ni = 1'b0;
        #1;
        tick();
        rst_ni = 1'b1;
        favour = 0;
        for (int h = 0; h < NH; h++) pend[h] = 1'b0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            // New requests only for hosts not waiting on a grant.
            for (int h = 0; h < NH; h++) begin
                if (!pend[h] && ($urandom_range(0, 1) == 1)) begin
                    pend[h] = 1'b1;
                    sel = $urandom_range(0, 4);
                    host_addr_i[h]  = {(sel < 2) ? 4'h0 : (sel < 4) ? 4'h1 : 4'hF, 28'($urandom)};
                    host_we_i[h]    = 1'($urandom);
                    host_be_i[h]    = 4'($urandom);
                    host_wdata_i[h] = $urandom;
                end
                host_req_i[h] = pend[h];
            end
            device_gnt_i      = 2'($urandom);
            device_rvalid_i   = 2'($urandom);
            device_rdata_i[0] = $urandom;
            device_rdata_i[1] = $urandom;
            #1;

            exp_rv = 2'b00;
            exp_err = 2'b00;
            for (int h = 0; h < NH; h++) exp_rdata[h] = '0;
            pop = (q.size() > 0) && ((q[0].dev < 0) || device_rvalid_i[q[0].dev]);
            if (pop) begin
                exp_rv[q[0].host] = 1'b1;
                if (q[0].dev < 0) exp_err[q[0].host] = 1'b1;
                else exp_rdata[q[0].host] = device_rdata_i[q[0].dev];
            end

            win = -1;
            for (int i = 0; i < NH; i++) begin
                if (win < 0 && pend[(favour + i) % NH]) win = (favour + i) % NH;
            end
            tgt = (win >= 0) ? ref_decode(host_addr_i[win]) : -1;
            allowed = (win >= 0) && (q.size() < MO || pop) &&
                      (q.size() == 0 || q[$].dev == tgt);
            grant = allowed && (tgt < 0 || device_gnt_i[tgt]);
            exp_dreq = 2'b00;
            exp_gnt  = 2'b00;
            if (allowed && tgt >= 0) exp_dreq[tgt] = 1'b1;
            if (grant) exp_gnt[win] = 1'b1;

            checks++;
            if (host_gnt_o !== exp_gnt) begin
                errors++;
                $display("FAIL rnd_gnt cyc%0d: got %b expected %b", cyc, host_gnt_o, exp_gnt);
            end
            checks++;
            if (device_req_o !== exp_dreq) begin
                errors++;
                $display("FAIL rnd_dreq cyc%0d: got %b expected %b", cyc, device_req_o, exp_dreq);
            end
            checks++;
            if (host_rvalid_o !== exp_rv || host_err_o !== exp_err) begin
                errors++;
                $display("FAIL rnd_rvalid cyc%0d: rvalid %b err %b expected %b %b", cyc, host_rvalid_o, host_err_o, exp_rv, exp_err);
            end
            for (int h = 0; h < NH; h++) begin
                checks++;
                if (host_rdata_o[h] !== exp_rdata[h]) begin
                    errors++;
                    $display("FAIL rnd_rdata%0d cyc%0d: got %h expected %h", h, cyc, host_rdata_o[h], exp_rdata[h]);
                end
            end
            for (int d = 0; d < ND; d++) begin
                exp_addr = exp_dreq[d] ? host_addr_i[win] : '0;
                checks++;
                if (device_addr_o[d] !== exp_addr ||
                    device_we_o[d] !== (exp_dreq[d] ? host_we_i[win] : 1'b0) ||
                    device_be_o[d] !== (exp_dreq[d] ? host_be_i[win] : 4'h0) ||
                    device_wdata_o[d] !== (exp_dreq[d] ? host_wdata_i[win] : 32'h0)) begin
                    errors++;
                    $display("FAIL rnd_fields%0d cyc%0d: addr %h expected %h", d, cyc, device_addr_o[d], exp_addr);
                end
            end

            if (pop) void'(q.pop_front());
            if (grant) begin
                t.host = win;
                t.dev  = tgt;
                q.push_back(t);
                pend[win] = 1'b0;
                favour = (win + 1) % NH;
            end
            tick();
        end
        idle();
    endtask

    initial begin
        cfg_base[0] = 32'h0000_0000;
        cfg_mask[0] = 32'hF000_0000;
        cfg_base[1] = 32'h1000_0000;
        cfg_mask[1] = 32'hF000_0000;
        idle();
        test_reset();
        test_round_robin();
        test_back_pressure();
        test_decode_miss();
        test_ordering();
        test_full_fifo();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
